// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared state encoding and grant constants for wb_arbiter_2m
package wb_arb_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;
    localparam int NUM_MASTERS = 2;
    localparam logic [1:0] GRANT_NONE = 2'b00;
endpackage

// File: rtl/wb_arb_watchdog.sv
// wb_arb_watchdog: slave-response timeout counter, used only when WB_ARB_TIMEOUT_EN is defined
module wb_arb_watchdog
    import wb_arb_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic active_i,
    input  logic stb_i,
    input  logic resp_i,
    output logic timeout_o
);
    logic [15:0] cnt;
    assign timeout_o = active_i && (cnt == LIMIT[15:0]);
    always_ff @(posedge clk_i) begin
        if (!rst_ni || !active_i || !stb_i || resp_i || timeout_o)
            cnt <= '0;
        else
            cnt <= cnt + 16'd1;
    end
endmodule

// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: two-master round-robin Wishbone B4 classic arbiter; define WB_ARB_TIMEOUT_EN for the slave watchdog
module wb_arbiter_2m
    import wb_arb_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 24,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   m0_cyc_i,
    input  logic                   m0_stb_i,
    input  logic                   m0_we_i,
    input  logic [ADDR_WIDTH-1:0]  m0_adr_i,
    input  logic [7:0]             m0_dat_i,
    output logic [7:0]             m0_dat_o,
    output logic                   m0_ack_o,
    output logic                   m0_err_o,
    output logic                   m0_rty_o,
    input  logic                   m1_cyc_i,
    input  logic                   m1_stb_i,
    input  logic                   m1_we_i,
    input  logic [ADDR_WIDTH-1:0]  m1_adr_i,
    input  logic [7:0]             m1_dat_i,
    output logic [7:0]             m1_dat_o,
    output logic                   m1_ack_o,
    output logic                   m1_err_o,
    output logic                   m1_rty_o,
    output logic                   s_cyc_o,
    output logic                   s_stb_o,
    output logic                   s_we_o,
    output logic [ADDR_WIDTH-1:0]  s_adr_o,
    output logic [7:0]             s_dat_o,
    input  logic [7:0]             s_dat_i,
    input  logic                   s_ack_i,
    input  logic                   s_err_i,
    input  logic                   s_rty_i,
    output logic [NUM_MASTERS-1:0] grant_o
);
    arb_state_t state, state_nxt;
    logic last;
    logic g0, g1, to;
    assign g0 = (state == GNT0);
    assign g1 = (state == GNT1);
    always_comb begin
        state_nxt = IDLE;
        if (state == IDLE)
            state_nxt = (m0_cyc_i && (!m1_cyc_i || last)) ? GNT0 : m1_cyc_i ? GNT1 : IDLE;
        else if (g0)
            state_nxt = m0_cyc_i ? GNT0 : IDLE;
        else if (g1)
            state_nxt = m1_cyc_i ? GNT1 : IDLE;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt != IDLE)
                last <= (state_nxt == GNT1);
        end
    end
`ifdef WB_ARB_TIMEOUT_EN
    wb_arb_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .active_i (g0 || g1),
        .stb_i    (g0 ? m0_stb_i : (g1 && m1_stb_i)),
        .resp_i   (s_ack_i || s_err_i || s_rty_i),
        .timeout_o(to)
    );
`else
    logic unused_to;
    assign to        = 1'b0;
    assign unused_to = ^TIMEOUT_CYCLES;
`endif
    assign s_cyc_o  = ((g0 && m0_cyc_i) || (g1 && m1_cyc_i)) && !to;
    assign s_stb_o  = ((g0 && m0_stb_i) || (g1 && m1_stb_i)) && !to;
    assign s_we_o   = (g0 && m0_we_i) || (g1 && m1_we_i);
    assign s_adr_o  = g0 ? m0_adr_i : g1 ? m1_adr_i : '0;
    assign s_dat_o  = g0 ? m0_dat_i : g1 ? m1_dat_i : '0;
    assign m0_dat_o = g0 ? s_dat_i : '0;
    assign m1_dat_o = g1 ? s_dat_i : '0;
    assign m0_ack_o = g0 && s_ack_i;
    assign m1_ack_o = g1 && s_ack_i;
    assign m0_err_o = g0 && (s_err_i || to);
    assign m1_err_o = g1 && (s_err_i || to);
    assign m0_rty_o = g0 && s_rty_i;
    assign m1_rty_o = g1 && s_rty_i;
    assign grant_o  = (g0 || g1) ? {g1, g0} : GRANT_NONE;
endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb_wb_arbiter_2m: self-checking bench for wb_arbiter_2m with a read-response scoreboard
module tb_wb_arbiter_2m;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [23:0] m0_adr_i;
    logic [7:0]  m0_dat_i, m0_dat_o;
    logic        m0_ack_o, m0_err_o, m0_rty_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [23:0] m1_adr_i;
    logic [7:0]  m1_dat_i, m1_dat_o;
    logic        m1_ack_o, m1_err_o, m1_rty_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [23:0] s_adr_o;
    logic [7:0]  s_dat_o, s_dat_i;
    logic        s_ack_i, s_err_i, s_rty_i;
    logic [1:0]  grant_o;

    typedef struct packed {
        logic       m;
        logic [7:0] d;
    } exp_t;
    exp_t sb[$];
    int n_chk = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    wb_arbiter_2m #(
        .ADDR_WIDTH(24),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
        .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
        .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .grant_o(grant_o)
    );

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_m(input int m, input logic c, input logic [23:0] a);
        if (m == 0) begin
            m0_cyc_i = c; m0_stb_i = c; m0_adr_i = a;
        end else begin
            m1_cyc_i = c; m1_stb_i = c; m1_adr_i = a;
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_dat_i = 8'h00;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_dat_i = 8'h00;
        s_dat_i = 8'h00; s_ack_i = 0; s_err_i = 0; s_rty_i = 0;
        sb.delete();
        cyc();
        cyc();
        rst_ni = 1'b1;
    endtask

    // slave acks this cycle; the scoreboard says who must see it and with what data
    task automatic ack_beat(input logic [7:0] d);
        exp_t e;
        logic [1:0] acks;
        logic [7:0] got;
        s_dat_i = d;
        s_ack_i = 1'b1;
        #1;
        n_chk++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL sb_empty: ack seen with nothing expected");
        end else begin
            e = sb.pop_front();
            acks = {m1_ack_o, m0_ack_o};
            got = e.m ? m1_dat_o : m0_dat_o;
            if (acks !== (e.m ? 2'b10 : 2'b01) || got !== e.d) begin
                n_err++;
                $display("FAIL sb_beat m%0d: acks=%b dat=%h expected acks=%b dat=%h",
                         e.m, acks, got, (e.m ? 2'b10 : 2'b01), e.d);
            end
        end
        cyc();
        s_ack_i = 1'b0;
        s_dat_i = 8'h00;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if (grant_o !== 2'b00 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: grant=%b cyc=%b stb=%b expected 00 0 0", grant_o, s_cyc_o, s_stb_o);
        end
        s_dat_i = 8'h55;
        s_ack_i = 1'b1;
        s_err_i = 1'b1;
        #1;
        n_chk++;
        if ({m0_dat_o, m1_dat_o} !== 16'h0 || {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_resp_gate: dat=%h/%h ack/err=%b expected 00/00 0000",
                     m0_dat_o, m1_dat_o, {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o});
        end
        s_dat_i = 8'h00; s_ack_i = 0; s_err_i = 0;
    endtask

    task automatic test_single();
        do_reset();
        set_m(1, 1'b1, 24'h000400);
        sb.push_back('{m: 1'b1, d: 8'h41});
        #1;
        n_chk++;
        if (s_cyc_o !== 1'b0) begin
            n_err++;
            $display("FAIL single_latency: s_cyc=%b expected 0", s_cyc_o);
        end
        cyc();
        n_chk++;
        if (grant_o !== 2'b10 || s_cyc_o !== 1'b1 || s_adr_o !== 24'h000400) begin
            n_err++;
            $display("FAIL single_grant: grant=%b cyc=%b adr=%h expected 10 1 000400", grant_o, s_cyc_o, s_adr_o);
        end
        ack_beat(8'h41);
        set_m(1, 1'b0, 24'h0);
        cyc();
        n_chk++;
        if (grant_o !== 2'b00) begin
            n_err++;
            $display("FAIL single_release: grant=%b expected 00", grant_o);
        end
    endtask

    task automatic test_contention();
        do_reset();
        set_m(0, 1'b1, 24'h000100);
        set_m(1, 1'b1, 24'h000200);
        sb.push_back('{m: 1'b0, d: 8'hA0});
        cyc();
        n_chk++;
        if (grant_o !== 2'b01 || s_adr_o !== 24'h000100) begin
            n_err++;
            $display("FAIL cont_first: grant=%b adr=%h expected 01 000100", grant_o, s_adr_o);
        end
        ack_beat(8'hA0);
        set_m(0, 1'b0, 24'h0);
        sb.push_back('{m: 1'b1, d: 8'hB1});
        cyc();
        n_chk++;
        if (grant_o !== 2'b00) begin
            n_err++;
            $display("FAIL cont_idle: grant=%b expected 00", grant_o);
        end
        cyc();
        n_chk++;
        if (grant_o !== 2'b10 || s_adr_o !== 24'h000200) begin
            n_err++;
            $display("FAIL cont_second: grant=%b adr=%h expected 10 000200", grant_o, s_adr_o);
        end
        ack_beat(8'hB1);
    endtask

    task automatic test_fairness();
        logic [23:0] adr;
        do_reset();
        set_m(0, 1'b1, 24'h000010);
        set_m(1, 1'b1, 24'h000020);
        for (int i = 0; i < 6; i++) begin
            cyc();
            adr = (i % 2 == 1) ? 24'h000020 : 24'h000010;
            n_chk++;
            if (grant_o !== ((i % 2 == 1) ? 2'b10 : 2'b01) || s_adr_o !== adr) begin
                n_err++;
                $display("FAIL fair_grant[%0d]: grant=%b adr=%h expected %b %h",
                         i, grant_o, s_adr_o, ((i % 2 == 1) ? 2'b10 : 2'b01), adr);
            end
            sb.push_back('{m: 1'(i % 2), d: 8'(8'h10 + i)});
            ack_beat(8'(8'h10 + i));
            set_m(i % 2, 1'b0, adr);
            cyc();
            n_chk++;
            if (grant_o !== 2'b00) begin
                n_err++;
                $display("FAIL fair_idle[%0d]: grant=%b expected 00", i, grant_o);
            end
            set_m(i % 2, 1'b1, adr);
        end
    endtask

    task automatic test_lock();
        do_reset();
        set_m(1, 1'b1, 24'h000202);
        cyc();
        set_m(0, 1'b1, 24'h000300);
        sb.push_back('{m: 1'b1, d: 8'hC2});
        ack_beat(8'hC2);
        set_m(1, 1'b1, 24'h000203);
        #1;
        n_chk++;
        if (grant_o !== 2'b10 || s_adr_o !== 24'h000203) begin
            n_err++;
            $display("FAIL lock_hold: grant=%b adr=%h expected 10 000203", grant_o, s_adr_o);
        end
        sb.push_back('{m: 1'b1, d: 8'hC3});
        ack_beat(8'hC3);
        n_chk++;
        if (grant_o !== 2'b10) begin
            n_err++;
            $display("FAIL lock_after: grant=%b expected 10", grant_o);
        end
        set_m(1, 1'b0, 24'h0);
        cyc();
        cyc();
        n_chk++;
        if (grant_o !== 2'b01 || s_adr_o !== 24'h000300) begin
            n_err++;
            $display("FAIL lock_m0_next: grant=%b adr=%h expected 01 000300", grant_o, s_adr_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_m(0, 1'b1, 24'h000050);
        cyc();
        n_chk++;
        if (grant_o !== 2'b01 || s_stb_o !== 1'b1) begin
            n_err++;
            $display("FAIL mid_grant: grant=%b stb=%b expected 01 1", grant_o, s_stb_o);
        end
        rst_ni = 1'b0;
        set_m(1, 1'b1, 24'h000060);
        cyc();
        n_chk++;
        if (s_cyc_o !== 1'b0 || grant_o !== 2'b00 || m0_ack_o !== 1'b0) begin
            n_err++;
            $display("FAIL mid_abort: cyc=%b grant=%b ack=%b expected 0 00 0", s_cyc_o, grant_o, m0_ack_o);
        end
        rst_ni = 1'b1;
        cyc();
        n_chk++;
        if (grant_o !== 2'b01) begin
            n_err++;
            $display("FAIL mid_pointer: grant=%b expected 01", grant_o);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        set_m(0, 1'b1, 24'h000070);
        cyc();
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (m0_err_o !== 1'b0 || s_stb_o !== 1'b1) begin
                n_err++;
                $display("FAIL to_stall[%0d]: err=%b stb=%b expected 0 1", k, m0_err_o, s_stb_o);
            end
            cyc();
        end
`ifdef WB_ARB_TIMEOUT_EN
        n_chk++;
        if (m0_err_o !== 1'b1 || s_stb_o !== 1'b0 || s_cyc_o !== 1'b0) begin
            n_err++;
            $display("FAIL to_pulse: err=%b stb=%b cyc=%b expected 1 0 0", m0_err_o, s_stb_o, s_cyc_o);
        end
`else
        n_chk++;
        if (m0_err_o !== 1'b0 || s_stb_o !== 1'b1) begin
            n_err++;
            $display("FAIL to_none: err=%b stb=%b expected 0 1", m0_err_o, s_stb_o);
        end
`endif
        cyc();
        n_chk++;
        if (m0_err_o !== 1'b0 || grant_o !== 2'b01) begin
            n_err++;
            $display("FAIL to_after: err=%b grant=%b expected 0 01", m0_err_o, grant_o);
        end
        set_m(0, 1'b0, 24'h0);
        cyc();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_lock();
        test_reset_mid();
        test_timeout();
        n_chk++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: %0d entries expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
